register_file: RTL and testbench
================================

# register_file

Parametrised multi-entry register file for the 8-bit datapath: one synchronous write port, two independent pipelined read ports that drive tri-stateable bus outputs, and a flattened bypass view of every entry. It replaces scattered single `register` instances with one addressable block and adds registered reads, read-valid tracking, out-of-range protection and optional same-cycle write forwarding.

## Interface
- `BIT_COUNT`, 8, width of each entry
- `REG_COUNT`, 4, number of entries (≥2; need not be a power of two)
- `ADDR_BITS`, `$clog2(REG_COUNT)`, address width (derived; do not override)

- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `write_en`  input  1  write strobe
- `write_addr`  input  ADDR_BITS  write entry index
- `reg_in`  input  BIT_COUNT  write data
- `read_en_a` / `read_en_b`  input  1  read request, port A / B
- `read_addr_a` / `read_addr_b`  input  ADDR_BITS  read entry index
- `reg_out_a` / `reg_out_b`  output  BIT_COUNT  read data; high-Z when port not valid
- `read_valid_a` / `read_valid_b`  output  1  port output is driving valid data
- `bypass_out`  output  REG_COUNT*BIT_COUNT  all entries, entry i at bits [i*BIT_COUNT +: BIT_COUNT], never tri-stated

## Operation
- Storage: REG_COUNT × BIT_COUNT flops, plus per-port output register (`BIT_COUNT`) and valid flop.
- Write: at edge with `write_en`=1 and `write_addr` < REG_COUNT, entry ← `reg_in`; otherwise entries hold.
- Out-of-range write (`write_addr` ≥ REG_COUNT): ignored, no entry changes.
- Read, per port independently: at edge, valid ← `read_en`; if `read_en`=1, output register ← selected entry (0 if address out of range); if `read_en`=0, output register holds (not visible, output is Z).
- `reg_out_x` = `read_valid_x` ? output register : all-Z.
- Both ports may read the same address in the same cycle; each returns identical data.
- Read-during-write to same in-range address, same edge: governed by Configuration.
- `bypass_out` reflects entry contents directly (post-edge), independent of read enables.
- Reset priority over everything: when `rst`=1 at an edge, writes and reads in that cycle are discarded.

## Timing
- Reset values (after edge with `rst`=1): all entries 0, output registers 0, `read_valid_a/b`=0, `reg_out_a/b`=Z, `bypass_out`=0.
- Write latency: data visible on `bypass_out` and to reads sampled at the following edge, 1 cycle after the write edge.
- Read latency: request sampled at edge N → `reg_out_x` valid and `read_valid_x`=1 from edge N through edge N+1; single-cycle pulse unless `read_en` held.
- Back-to-back reads: one result per cycle per port, no bubbles.
- Reset asserted mid-stream: outputs go Z/valid 0 at the reset edge; pipeline holds no residual result after `rst` deasserts.
- No combinational path from inputs to outputs.

## Configuration
- Macro `REGFILE_WRITE_FWD_EN`.
- Defined: same-edge read and write to the same in-range address returns `reg_in` (new data) on the read port.
- Undefined: same case returns the entry's pre-write (old) value; new value visible to reads sampled at the next edge.
- Forwarding never applies to out-of-range write addresses; out-of-range reads still return 0.

## Test plan
- Reset: drive `rst`=1 one edge after writing 0xAA to entry 2 → `bypass_out`=0, `read_valid_a/b`=0, `reg_out_a/b`=Z.
- Write/read: write 0x5C to entry 1, next cycle `read_en_a`=1 addr 1 and `read_en_b`=1 addr 1 → one edge later both outputs 0x5C, both valid=1; following cycle with `read_en`=0 → Z, valid 0.
- Same-cycle hazard: entry 3 = 0x11, then write 0x77 to entry 3 while reading entry 3 on A → A returns 0x77 with `REGFILE_WRITE_FWD_EN`, 0x11 without; entry 3 = 0x77 afterward in both builds.
- Out-of-range (REG_COUNT=3): write 0xFF to addr 3 → `bypass_out` unchanged; read addr 3 → 0x00, valid 1.
- Reset mid-read: `read_en_a`=1 and `rst`=1 same edge → valid 0, output Z; first read after `rst` deasserts returns 0x00.
- Width/depth sweep: BIT_COUNT=16, REG_COUNT=8, write i·0x0101 to entry i then read all on alternating ports back-to-back → each returns its pattern, one per cycle per port.

Source files
------------

// File: rtl/register_file.sv
// register_file: multi-entry register file with one synchronous write port,
// two independent registered read ports driving tri-stateable outputs, and a
// flattened bypass view of every entry.
//
// Optional feature macro: REGFILE_WRITE_FWD_EN
//   defined   -> a read and a write to the same in-range entry on the same
//                edge return the write data (new value) on the read port
//   undefined -> the read returns the entry's pre-write (old) value
//
// Out-of-range addresses (>= REG_COUNT) are safe: writes are dropped and
// reads return zero. Reset is synchronous, active-high, and wins over any
// read or write presented on the same edge.

module register_file #(
    parameter  int unsigned BIT_COUNT = 8,
    parameter  int unsigned REG_COUNT = 4,
    localparam int unsigned ADDR_BITS = $clog2(REG_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           write_en,
    input  logic [ADDR_BITS-1:0]           write_addr,
    input  logic [BIT_COUNT-1:0]           reg_in,

    input  logic                           read_en_a,
    input  logic [ADDR_BITS-1:0]           read_addr_a,
    output logic [BIT_COUNT-1:0]           reg_out_a,
    output logic                           read_valid_a,

    input  logic                           read_en_b,
    input  logic [ADDR_BITS-1:0]           read_addr_b,
    output logic [BIT_COUNT-1:0]           reg_out_b,
    output logic                           read_valid_b,

    output logic [REG_COUNT*BIT_COUNT-1:0] bypass_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BIT_COUNT-1:0] mem_q [REG_COUNT];
    logic [BIT_COUNT-1:0] mem_d [REG_COUNT];

    logic [BIT_COUNT-1:0] data_a_q, data_a_d;
    logic [BIT_COUNT-1:0] data_b_q, data_b_d;
    logic                 valid_a_q, valid_a_d;
    logic                 valid_b_q, valid_b_d;

    // Per-entry write strobe; all-zero for out-of-range addresses
    logic [REG_COUNT-1:0] wr_sel;

    // Decode the write address into a one-hot entry strobe
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (write_en && (write_addr == ADDR_BITS'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    // Next-state of the storage array: selected entry takes reg_in
    always_comb begin
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_sel[i]) begin
                mem_d[i] = reg_in;
            end
        end
    end

    // Port A read mux: zero when out of range, optionally forwards reg_in
    always_comb begin
        data_a_d  = data_a_q;
        valid_a_d = read_en_a;
        if (read_en_a) begin
            data_a_d = '0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (read_addr_a == ADDR_BITS'(i)) begin
`ifdef REGFILE_WRITE_FWD_EN
                    data_a_d = wr_sel[i] ? reg_in : mem_q[i];
`else
                    data_a_d = mem_q[i];
`endif
                end
            end
        end
    end

    // Port B read mux: zero when out of range, optionally forwards reg_in
    always_comb begin
        data_b_d  = data_b_q;
        valid_b_d = read_en_b;
        if (read_en_b) begin
            data_b_d = '0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (read_addr_b == ADDR_BITS'(i)) begin
`ifdef REGFILE_WRITE_FWD_EN
                    data_b_d = wr_sel[i] ? reg_in : mem_q[i];
`else
                    data_b_d = mem_q[i];
`endif
                end
            end
        end
    end

    // Storage array update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read output registers and valid flags with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: read ports float when not valid, bypass is always driven
    // ------------------------------------------------------------------
    assign read_valid_a = valid_a_q;
    assign read_valid_b = valid_b_q;
    assign reg_out_a    = valid_a_q ? data_a_q : {BIT_COUNT{1'bz}};
    assign reg_out_b    = valid_b_q ? data_b_q : {BIT_COUNT{1'bz}};

    // Flatten the entries, entry i at bits [i*BIT_COUNT +: BIT_COUNT]
    always_comb begin
        bypass_out = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            bypass_out[i*BIT_COUNT +: BIT_COUNT] = mem_q[i];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random
// traffic, with a queue-based scoreboard fed by an array reference model.
// Uses REG_COUNT=5 so addresses 5..7 exercise out-of-range handling.

module tb_register_file;

    localparam int unsigned BW = 8;
    localparam int unsigned RC = 5;
    localparam int unsigned AW = $clog2(RC);

    typedef struct {
        logic                va;
        logic                vb;
        logic [BW-1:0]       da;
        logic [BW-1:0]       db;
        logic [RC*BW-1:0]    byp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic write_en;
    logic [AW-1:0] write_addr;
    logic [BW-1:0] reg_in;
    logic read_en_a, read_en_b;
    logic [AW-1:0] read_addr_a, read_addr_b;
    wire  [BW-1:0] reg_out_a, reg_out_b;
    logic read_valid_a, read_valid_b;
    logic [RC*BW-1:0] bypass_out;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    // Reference model state
    logic [BW-1:0] m_mem [RC];
    logic [BW-1:0] m_da, m_db;
    logic          m_va, m_vb;

    always #5 clk = ~clk;

    register_file #(.BIT_COUNT(BW), .REG_COUNT(RC)) dut (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .reg_in      (reg_in),
        .read_en_a   (read_en_a),
        .read_addr_a (read_addr_a),
        .reg_out_a   (reg_out_a),
        .read_valid_a(read_valid_a),
        .read_en_b   (read_en_b),
        .read_addr_b (read_addr_b),
        .reg_out_b   (reg_out_b),
        .read_valid_b(read_valid_b),
        .bypass_out  (bypass_out)
    );

    // What a read of addr returns at an edge that may also carry a write
    function automatic logic [BW-1:0] ref_read(input int unsigned addr, input logic we,
                                               input int unsigned wa, input logic [BW-1:0] d);
        if (addr >= RC) return '0;
`ifdef REGFILE_WRITE_FWD_EN
        if (we && wa == addr) return d;
`endif
        return m_mem[addr];
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expectation
    task automatic step(input logic r, input logic we, input int unsigned wa, input logic [BW-1:0] d,
                        input logic rea, input int unsigned raa,
                        input logic reb, input int unsigned rab);
        exp_t e;
        logic [BW-1:0] na, nb;
        rst = r; write_en = we; write_addr = AW'(wa); reg_in = d;
        read_en_a = rea; read_addr_a = AW'(raa);
        read_en_b = reb; read_addr_b = AW'(rab);
        if (r) begin
            for (int i = 0; i < int'(RC); i++) m_mem[i] = '0;
            m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0;
        end else begin
            na = ref_read(raa, we, wa, d);
            nb = ref_read(rab, we, wa, d);
            if (rea) m_da = na;
            if (reb) m_db = nb;
            m_va = rea;
            m_vb = reb;
            if (we && wa < RC) m_mem[wa] = d;
        end
        e.va = m_va; e.vb = m_vb; e.da = m_da; e.db = m_db;
        for (int i = 0; i < int'(RC); i++) e.byp[i*BW +: BW] = m_mem[i];
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
    endtask

    // Monitor: after every edge, pop the expectation and compare all outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation at t=%0t: DUT output with empty scoreboard", $time);
            end else begin
                e = exp_q.pop_front();
                if (read_valid_a !== e.va) begin
                    errors++;
                    $display("FAIL valid_a t=%0t got=%b exp=%b", $time, read_valid_a, e.va);
                end
                checks++;
                if (read_valid_b !== e.vb) begin
                    errors++;
                    $display("FAIL valid_b t=%0t got=%b exp=%b", $time, read_valid_b, e.vb);
                end
                checks++;
                if (e.va ? (reg_out_a !== e.da) : (reg_out_a !== {BW{1'bz}})) begin
                    errors++;
                    $display("FAIL data_a t=%0t got=%h exp=%h (valid=%b)", $time, reg_out_a, e.da, e.va);
                end
                checks++;
                if (e.vb ? (reg_out_b !== e.db) : (reg_out_b !== {BW{1'bz}})) begin
                    errors++;
                    $display("FAIL data_b t=%0t got=%h exp=%h (valid=%b)", $time, reg_out_b, e.db, e.vb);
                end
                checks++;
                if (bypass_out !== e.byp) begin
                    errors++;
                    $display("FAIL bypass t=%0t got=%h exp=%h", $time, bypass_out, e.byp);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        for (int i = 0; i < int'(RC); i++) m_mem[i] = '0;
        m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0;

        // Initial reset
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);

        // Reset clears a freshly written entry
        step(1'b0, 1'b1, 2, 8'hAA, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 0, '0, 1'b1, 2, 1'b1, 2);
        idle();

        // Write then dual read of the same entry, then release
        step(1'b0, 1'b1, 1, 8'h5C, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, '0, 1'b1, 1, 1'b1, 1);
        idle();

        // Same-edge read/write hazard on entry 3
        step(1'b0, 1'b1, 3, 8'h11, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, 3, 8'h77, 1'b1, 3, 1'b0, 0);
        step(1'b0, 1'b0, 0, '0, 1'b1, 3, 1'b1, 3);

        // Out-of-range write is dropped, out-of-range read returns zero
        step(1'b0, 1'b1, 6, 8'hFF, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, 5, 8'hFF, 1'b1, 6, 1'b1, 7);
        idle();

        // Reset coinciding with a read, then first read afterwards
        step(1'b1, 1'b0, 0, '0, 1'b1, 1, 1'b0, 0);
        step(1'b0, 1'b0, 0, '0, 1'b1, 1, 1'b0, 0);

        // Fill every entry, then back-to-back reads on alternating ports
        for (int i = 0; i < int'(RC); i++)
            step(1'b0, 1'b1, i, BW'((i + 1) * 8'h11), 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < int'(RC); i++)
            step(1'b0, 1'b0, 0, '0, (i % 2) == 0, i, (i % 2) == 1, i);
        for (int i = 0; i < int'(RC); i++)
            step(1'b0, 1'b0, 0, '0, 1'b1, i, 1'b1, RC - 1 - i);
        idle();

        // Random traffic, addresses across the full (partly invalid) range
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 55, $urandom_range(0, (1 << AW) - 1), BW'($urandom),
                 $urandom_range(0, 99) < 60, $urandom_range(0, (1 << AW) - 1),
                 $urandom_range(0, 99) < 60, $urandom_range(0, (1 << AW) - 1));
        end
        idle();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
